// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment display path: bit positions and the
// active-high hex glyph table (index = nibble value).
package seg_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam logic [7:0] SEG_OFF = 8'h00;

  // Entry 15 first: packed arrays list the highest index on the left.
  localparam logic [15:0][6:0] HEX_TAB = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/seg_hex_dec.sv
// Hex nibble to active-high a..g segment pattern.
module seg_hex_dec
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] pat
);

  assign pat = HEX_TAB[nib];

endmodule

// File: rtl/seg_scan_drv.sv
// Time-multiplexed seven-segment driver: one digit per scan_clk rising edge,
// frame-coherent snapshot of the inputs, leading-zero suppression and blanking.
module seg_scan_drv
  import seg_pkg::*;
#(
  parameter int NUM_DIG     = 8,
  parameter bit SEG_ACT_LOW = 1'b1,
  parameter bit DIG_ACT_LOW = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 scan_clk,
  input  logic [4*NUM_DIG-1:0] data,
  input  logic [NUM_DIG-1:0]   dp,
  input  logic [NUM_DIG-1:0]   blank,
  input  logic                 lz_en,
  output logic [7:0]           seg,
  output logic [NUM_DIG-1:0]   dig_sel,
  output logic                 frame_done
);

  localparam int               IW        = $clog2(NUM_DIG);
  localparam logic [IW-1:0]    IDX_LAST  = IW'(NUM_DIG - 1);
  localparam logic [7:0]       SEG_INACT = SEG_ACT_LOW ? 8'hFF : 8'h00;
  localparam logic [NUM_DIG-1:0] DIG_INACT = DIG_ACT_LOW ? {NUM_DIG{1'b1}} : {NUM_DIG{1'b0}};

  logic s1, s2, s3;
  logic sync_vld, armed;
  logic step;

  // armed only after a genuine low has been sampled post-reset, so releasing
  // reset while scan_clk is high cannot masquerade as a rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      s3       <= 1'b0;
      sync_vld <= 1'b0;
      armed    <= 1'b0;
    end else begin
      s1       <= scan_clk;
      s2       <= s1;
      s3       <= s2;
      sync_vld <= 1'b1;
      armed    <= armed | (sync_vld & ~s1);
    end
  end

  assign step = s2 & ~s3 & armed;

  logic [IW-1:0]        idx, idx_nxt;
  logic                 wrap;
  logic [4*NUM_DIG-1:0] sh_data, src_data;
  logic [NUM_DIG-1:0]   sh_dp, sh_blank, src_dp, src_blank;
  logic                 sh_lz, src_lz;

  assign wrap    = (idx == IDX_LAST);
  assign idx_nxt = wrap ? '0 : idx + 1'b1;

  // Digit 0 is emitted on the wrap edge itself, so it reads the live inputs.
  assign src_data  = wrap ? data  : sh_data;
  assign src_dp    = wrap ? dp    : sh_dp;
  assign src_blank = wrap ? blank : sh_blank;
  assign src_lz    = wrap ? lz_en : sh_lz;

  logic [NUM_DIG-1:0] lead_zero;
  logic               seen_nz;

  always_comb begin
    lead_zero = '0;
    seen_nz   = 1'b0;
    for (int d = NUM_DIG - 1; d >= 0; d--) begin
      seen_nz      = seen_nz | (|src_data[4*d +: 4]);
      lead_zero[d] = ~seen_nz;
    end
  end

  logic [3:0]         nib_sel;
  logic [6:0]         glyph;
  logic               suppress;
  logic [7:0]         pat_hi, seg_nxt;
  logic [NUM_DIG-1:0] dig_oh;

  assign nib_sel = src_data[{idx_nxt, 2'b00} +: 4];

  seg_hex_dec u_dec (
    .nib (nib_sel),
    .pat (glyph)
  );

  assign suppress = src_lz & lead_zero[idx_nxt] & (idx_nxt != '0);

  always_comb begin
    pat_hi                = SEG_OFF;
    pat_hi[SEG_G:SEG_A]   = suppress ? 7'h00 : glyph;
    pat_hi[SEG_DP]        = src_dp[idx_nxt];
    if (src_blank[idx_nxt]) pat_hi = SEG_OFF;
  end

  assign seg_nxt = SEG_ACT_LOW ? ~pat_hi : pat_hi;
  assign dig_oh  = NUM_DIG'(1) << idx_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= IDX_LAST;
      sh_data    <= '0;
      sh_dp      <= '0;
      sh_blank   <= '0;
      sh_lz      <= 1'b0;
      seg        <= SEG_INACT;
      dig_sel    <= DIG_INACT;
      frame_done <= 1'b0;
    end else begin
      frame_done <= step & wrap;
      if (step) begin
        idx     <= idx_nxt;
        seg     <= seg_nxt;
        dig_sel <= DIG_ACT_LOW ? ~dig_oh : dig_oh;
        if (wrap) begin
          sh_data  <= data;
          sh_dp    <= dp;
          sh_blank <= blank;
          sh_lz    <= lz_en;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_drv.sv
// Bench for seg_scan_drv: per-frame vector table expanded into per-step
// expectations, checked by a cycle-stamped scoreboard monitor.
module tb_seg_scan_drv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        scan_clk;
  logic [31:0] data;
  logic [7:0]  dp, blank;
  logic        lz_en;
  logic [7:0]  seg, dig_sel;
  logic        frame_done;

  seg_scan_drv u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .scan_clk   (scan_clk),
    .data       (data),
    .dp         (dp),
    .blank      (blank),
    .lz_en      (lz_en),
    .seg        (seg),
    .dig_sel    (dig_sel),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic [7:0] seg;
    logic [7:0] dig;
    logic       fd;
  } exp_t;

  typedef struct {
    logic [31:0] d_early;
    logic [31:0] d_late;
    logic [7:0]  dp;
    logic [7:0]  blank;
    logic        lz;
    logic [63:0] segs;
  } frame_t;

  typedef struct {
    logic [31:0] data;
    logic [7:0]  dp;
    logic [7:0]  blank;
    logic        lz;
    logic [7:0]  seg;
    logic [7:0]  dig;
    logic        fd;
  } row_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_pass = 0;
  int   n_tot  = 0;
  logic [7:0] last_seg = 8'hFF;
  logic [7:0] last_dig = 8'hFF;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_seg", seg, 8'hFF);
      chk("rst_dig", dig_sel, 8'hFF);
      chk("rst_fd", {7'd0, frame_done}, 8'h00);
      q.delete();
      last_seg = 8'hFF;
      last_dig = 8'hFF;
    end else if (q.size() > 0 && q[0].due == cyc) begin
      exp_t e;
      e = q.pop_front();
      chk("step_seg", seg, e.seg);
      chk("step_dig", dig_sel, e.dig);
      chk("step_fd", {7'd0, frame_done}, {7'd0, e.fd});
      last_seg = e.seg;
      last_dig = e.dig;
    end else begin
      chk("hold_seg", seg, last_seg);
      chk("hold_dig", dig_sel, last_dig);
      chk("idle_fd", {7'd0, frame_done}, 8'h00);
    end
  end

  // Rising edge on scan_clk at a negedge: E0, E1, E2 are the next three
  // posedges, so the update is visible at the negedge after the third one.
  task automatic scan_step(input logic [7:0] es, input logic [7:0] ed, input logic efd);
    exp_t e;
    @(negedge clk);
    scan_clk = 1'b1;
    e.due = cyc + 3;
    e.seg = es;
    e.dig = ed;
    e.fd  = efd;
    q.push_back(e);
    repeat (10) @(negedge clk);
    scan_clk = 1'b0;
    repeat (9) @(negedge clk);
  endtask

  frame_t frames[6];
  row_t   rows[48];

  initial begin
    frames[0] = '{32'h12345678, 32'h12345678, 8'h00, 8'h00, 1'b0, 64'hF9A4B0999282F880};
    frames[1] = '{32'h00000A05, 32'h00000A05, 8'h04, 8'h00, 1'b1, 64'hFFFFFFFFFF08C092};
    frames[2] = '{32'h00000000, 32'h00000000, 8'h00, 8'h00, 1'b1, 64'hFFFFFFFFFFFFFFC0};
    frames[3] = '{32'h11111111, 32'h11111111, 8'h01, 8'h01, 1'b0, 64'hF9F9F9F9F9F9F9FF};
    frames[4] = '{32'h11111111, 32'h22222222, 8'h00, 8'h00, 1'b0, 64'hF9F9F9F9F9F9F9F9};
    frames[5] = '{32'h22222222, 32'h22222222, 8'h00, 8'h00, 1'b0, 64'hA4A4A4A4A4A4A4A4};
    for (int f = 0; f < 6; f++) begin
      for (int d = 0; d < 8; d++) begin
        rows[f*8+d].data  = (d >= 4) ? frames[f].d_late : frames[f].d_early;
        rows[f*8+d].dp    = frames[f].dp;
        rows[f*8+d].blank = frames[f].blank;
        rows[f*8+d].lz    = frames[f].lz;
        rows[f*8+d].seg   = frames[f].segs[8*d +: 8];
        rows[f*8+d].dig   = ~(8'h01 << d);
        rows[f*8+d].fd    = (d == 0);
      end
    end

    rst_n    = 1'b0;
    scan_clk = 1'b1;
    data     = '0;
    dp       = '0;
    blank    = '0;
    lz_en    = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    // Released with scan_clk high: outputs must stay inactive.
    repeat (20) @(negedge clk);
    scan_clk = 1'b0;
    repeat (10) @(negedge clk);

    for (int r = 0; r < 48; r++) begin
      data  = rows[r].data;
      dp    = rows[r].dp;
      blank = rows[r].blank;
      lz_en = rows[r].lz;
      scan_step(rows[r].seg, rows[r].dig, rows[r].fd);
    end

    repeat (200) @(negedge clk);

    data  = 32'h12345678;
    dp    = '0;
    blank = '0;
    lz_en = 1'b0;
    scan_step(8'h80, 8'hFE, 1'b1);
    scan_step(8'hF8, 8'hFD, 1'b0);
    scan_step(8'h82, 8'hFB, 1'b0);

    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_seg", seg, 8'hFF);
    chk("async_rst_dig", dig_sel, 8'hFF);
    chk("async_rst_fd", {7'd0, frame_done}, 8'h00);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    scan_step(8'h80, 8'hFE, 1'b1);
    scan_step(8'hF8, 8'hFD, 1'b0);

    repeat (5) @(negedge clk);
    chk("queue_drained", 8'(q.size()), 8'h00);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
